synchronous_fifo: RTL and testbench

Single-clock first-in/first-out buffer with push/pop handshake, occupancy count and empty/almost-empty/almost-full/full status flags. It decouples a producer and a consumer running on the same clock. It is a generic datapath building block; flags and count drive upstream throttling and downstream scheduling.

---
 rtl/synchronous_fifo_pkg.sv | 26 ++
 rtl/synchronous_fifo_mem.sv | 56 +++++
 rtl/synchronous_fifo.sv | 94 +++++++++
 tb/tb_synchronous_fifo.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/synchronous_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | synchronous_fifo_pkg                                                 |
// | Shared status-flag type and occupancy decode for synchronous_fifo.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package synchronous_fifo_pkg;

  typedef struct packed {
    logic empty;
    logic almostempty;
    logic almostfull;
    logic full;
  } fifo_flags_t;

  function automatic fifo_flags_t decode_flags(input int unsigned num, input int unsigned depth);
    fifo_flags_t f;
    f.empty       = (num == 32'd0);
    f.almostempty = (num == 32'd1);
    f.almostfull  = (num == depth - 32'd1);
    f.full        = (num == depth);
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/synchronous_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | synchronous_fifo_mem                                                 |
// | Dual-port register array: one write port, one registered read port.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module synchronous_fifo_mem #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  localparam int c_depth = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem_q [c_depth];
  logic [DWIDTH-1:0] mem_d [c_depth];
  logic [DWIDTH-1:0] rdata_q;
  logic [DWIDTH-1:0] rdata_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage is intentionally left unreset; only the read register is cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Reading mem_q (not mem_d) returns the old word when the same slot is rewritten.
  always_comb begin
    rdata_d = re ? mem_q[raddr] : rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/synchronous_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | synchronous_fifo                                                     |
// | Single-clock FIFO with occupancy count and empty/full status flags.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module synchronous_fifo
  import synchronous_fifo_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4,
  parameter int DEPTH  = 2 ** AWIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] in,
  input  logic              push,
  input  logic              pop,
  output logic [DWIDTH-1:0] out,
  output logic [AWIDTH:0]   num,
  output logic              empty,
  output logic              almostempty,
  output logic              almostfull,
  output logic              full
);

  localparam logic [AWIDTH-1:0] c_ptr_one = AWIDTH'(1);
  localparam logic [AWIDTH:0]   c_num_one = (AWIDTH + 1)'(1);

  logic [AWIDTH-1:0] wp_q, wp_d;
  logic [AWIDTH-1:0] rp_q, rp_d;
  logic [AWIDTH:0]   num_q, num_d;
  logic              w_push_ok;
  logic              w_pop_ok;
  fifo_flags_t       w_flags;

  // Flags come only from the count register, so no input reaches an output combinationally.
  assign w_flags = decode_flags(32'(num_q), 32'(DEPTH));

  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign w_push_ok = push & (~w_flags.full | pop);
  assign w_pop_ok  = pop & ~w_flags.empty;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    num_d = num_q;
    if (w_push_ok) begin
      wp_d = wp_q + c_ptr_one;
    end
    if (w_pop_ok) begin
      rp_d = rp_q + c_ptr_one;
    end
    if (w_push_ok && !w_pop_ok) begin
      num_d = num_q + c_num_one;
    end else if (w_pop_ok && !w_push_ok) begin
      num_d = num_q - c_num_one;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      num_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      num_q <= num_d;
    end
  end

  synchronous_fifo_mem #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (w_push_ok),
    .waddr (wp_q),
    .wdata (in),
    .re    (w_pop_ok),
    .raddr (rp_q),
    .rdata (out)
  );

  assign num         = num_q;
  assign empty       = w_flags.empty;
  assign almostempty = w_flags.almostempty;
  assign almostfull  = w_flags.almostfull;
  assign full        = w_flags.full;

endmodule
`default_nettype wire

// File: tb/tb_synchronous_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_synchronous_fifo                                                  |
// | Directed self-checking bench for synchronous_fifo (16 x 16).         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_synchronous_fifo;

  logic        clk;
  logic        reset;
  logic [15:0] in_r;
  logic        push_r;
  logic        pop_r;
  logic [15:0] out_w;
  logic [4:0]  num_w;
  logic        empty_w;
  logic        almostempty_w;
  logic        almostfull_w;
  logic        full_w;

  int n_cmp;
  int n_mis;

  synchronous_fifo #(
    .DWIDTH (16),
    .AWIDTH (4),
    .DEPTH  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in_r),
    .push        (push_r),
    .pop         (pop_r),
    .out         (out_w),
    .num         (num_w),
    .empty       (empty_w),
    .almostempty (almostempty_w),
    .almostfull  (almostfull_w),
    .full        (full_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s", tag);
    end
  endtask

  // Count plus all four flags, expected values derived from the count alone.
  task automatic check_state(input string tag, input int exp_num);
    check({tag, ".num"},         32'(num_w),         32'(exp_num));
    check({tag, ".empty"},       32'(empty_w),       32'(exp_num == 0));
    check({tag, ".almostempty"}, 32'(almostempty_w), 32'(exp_num == 1));
    check({tag, ".almostfull"},  32'(almostfull_w),  32'(exp_num == 15));
    check({tag, ".full"},        32'(full_w),        32'(exp_num == 16));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic tick(input logic p, input logic q, input logic [15:0] d);
    push_r = p;
    pop_r  = q;
    in_r   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_mis  = 0;
    push_r = 1'b0;
    pop_r  = 1'b0;
    in_r   = 16'h0;
    reset  = 1'b0;

    // Reset held for two edges
    @(posedge clk); @(posedge clk); #1;
    check_state("reset", 0);
    check("reset.out", 32'(out_w), 32'h0);
    reset = 1'b1;
    tick(1'b0, 1'b0, 16'h0);
    check_state("idle", 0);
    check("idle.out", 32'(out_w), 32'h0);

    // Fill 0..15
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b0, 16'(i));
      check_state("fill", i + 1);
      check("fill.out", 32'(out_w), 32'h0);
    end

    // Overflow 16..31 dropped
    for (int i = 16; i < 32; i++) begin
      tick(1'b1, 1'b0, 16'(i));
      check_state("ovf", 16);
    end

    // Drain 0..15
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b1, 16'h0);
      check("drain.out", 32'(out_w), 32'(i));
      check_state("drain", 15 - i);
    end

    // Refill 0..15, then eight simultaneous push/pop while full
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b0, 16'(i));
    end
    check_state("refill", 16);
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b1, 16'(24 + k));
      check("fullpp.out", 32'(out_w), 32'(k));
      check_state("fullpp", 16);
    end
    // Remaining order: 8..15 then 24..31
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b1, 16'h0);
      check("fulldrain.out", 32'(out_w), (i < 8) ? 32'(8 + i) : 32'(16 + i));
      check_state("fulldrain", 15 - i);
    end

    // Empty corner cases; out holds 31 from the last pop
    tick(1'b0, 1'b1, 16'h0);
    check("emptypop.out", 32'(out_w), 32'd31);
    check_state("emptypop", 0);
    tick(1'b1, 1'b1, 16'hABCD);
    check("emptypp.out", 32'(out_w), 32'd31);
    check_state("emptypp", 1);
    tick(1'b0, 1'b1, 16'h0);
    check("emptypp_pop.out", 32'(out_w), 32'hABCD);
    check_state("emptypp_pop", 0);

    // Wrap: push 10, pop 8, push 12
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 16'(100 + i));
    end
    check_state("wrap_push10", 10);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 16'h0);
      check("wrap_pop8.out", 32'(out_w), 32'(100 + i));
    end
    check_state("wrap_pop8", 2);
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0, 16'(200 + i));
    end
    check_state("wrap_push12", 14);
    for (int i = 0; i < 14; i++) begin
      tick(1'b0, 1'b1, 16'h0);
      check("wrap_drain.out", 32'(out_w), (i < 2) ? 32'(108 + i) : 32'(198 + i));
    end
    check_state("wrap_drain", 0);

    // Mid-operation asynchronous reset with 14 entries held
    for (int i = 0; i < 14; i++) begin
      tick(1'b1, 1'b0, 16'(300 + i));
    end
    push_r = 1'b0;
    check_state("prereset", 14);
    check("prereset.out", 32'(out_w), 32'd211);
    #2;
    reset = 1'b0;
    #1;
    check_state("async_reset", 0);
    check("async_reset.out", 32'(out_w), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick(1'b0, 1'b1, 16'h0);
    check("post_reset_pop.out", 32'(out_w), 32'h0);
    check_state("post_reset", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
